decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32: register/operand width.
REQ-002 Parameter NREGS, default 32: architectural register count, power of two >= 2; RA = $clog2(NREGS).
REQ-003 Parameter WB_PORTS, default 2: number of independent writeback channels.
REQ-004 Parameter PCW, default 8: jump-target width.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 in_valid / in_ready  input / output  1 each  instruction handshake from fetch.
REQ-008 in_instr  input  32  MIPS-format instruction word.
REQ-009 wb_en  input  [WB_PORTS]  per-channel register write enable.
REQ-010 wb_addr / wb_data  input  [WB_PORTS][RA] / [WB_PORTS][XLEN]  writeback address and data.
REQ-011 out_valid / out_ready  output / input  1 each  decoded-bundle handshake to execute.
REQ-012 out_op  output  6  opcode; out_rs_a, out_rt_a, out_rd_a  output  RA each  source and destination addresses.
REQ-013 out_rs, out_rt  output  XLEN  operand values; out_imm  output  XLEN  sign-extended instr[15:0].
REQ-014 out_pc_jmp  output  PCW  instr[PCW-1:0]; stall_cnt  output  16  hazard-stall counter.

Function
REQ-015 Decoding SHALL be: RTYPE(0x00) src rs,rt dst rd; ADDI(0x08) and LW(0x23) src rs dst rt; BEQ(0x04) and SW(0x2B) src rs,rt, no dst; J(0x02) and any other opcode: no src, no dst; unused address fields output 0.
REQ-016 Register 0 SHALL always read 0; writes to it SHALL be ignored and it SHALL never be marked pending.
REQ-017 Same-cycle writes to one address on several channels: the highest channel index SHALL win.
REQ-018 A per-register pending bit (scoreboard) SHALL be set on issue (in_valid && in_ready) for a nonzero dst and cleared by any wb_en to that address.
REQ-019 Simultaneous set and clear of one register in one cycle: set SHALL win.
REQ-020 hazard SHALL be asserted while any used source register is pending and not being written this cycle (see REQ-029).
REQ-021 in_ready SHALL equal (!out_valid || out_ready) && !hazard, combinationally.
REQ-022 Latency SHALL be one cycle: all out_* fields are registered at issue, and out_valid rises on the next edge.
REQ-023 While out_valid && !out_ready, every out_* SHALL hold stable; later writebacks SHALL NOT change captured operands.
REQ-024 Back-to-back issue SHALL sustain one instruction per cycle when out_ready is held high and no hazard exists.
REQ-025 stall_cnt SHALL increment in each cycle with in_valid && hazard, saturating at 0xFFFF.

Reset
REQ-026 While reset is low at a clock edge, out_valid, all out_* fields, stall_cnt, the scoreboard and every register-file entry SHALL become 0.
REQ-027 Reset mid-stall or mid-backpressure SHALL discard the held bundle; no handshake completes in the reset cycle.
REQ-028 The first issue SHALL be possible in the first cycle after reset is released.

Configuration
REQ-029 With DECODE_BYPASS_EN defined, a source written this cycle on any wb channel SHALL clear the hazard and capture wb_data (winner per REQ-017).
REQ-030 Without DECODE_BYPASS_EN, such a source SHALL stay hazarded for that cycle, and the instruction SHALL issue one cycle later from the register file.

Structure
REQ-031 The opcode enum, decode-class typedef and PCW default SHALL live in the shared definitions package.
REQ-032 The register storage SHALL be the sub-module regfile_mp: WB_PORTS write ports, two asynchronous read ports, register 0 hardwired to 0.

Verification
REQ-033 Sequence ADDI r1,r0,5 then RTYPE add r2,r1,r1 with no wb: the second instruction stalls; stall_cnt counts each cycle.
REQ-034 Same stall, then wb_en[0]=1, addr=1, data=5: with bypass, the add issues that cycle with out_rs=out_rt=5; without bypass it issues one cycle later.
REQ-035 wb ch0 and ch1 both write r3 (0xA, 0xB) in one cycle, then SW reads r3: out_rt = 0xB.
REQ-036 out_ready held low for 4 cycles with out_valid high: out_* stable and in_ready low; when out_ready rises, the next instruction issues the same cycle.
REQ-037 Instruction J with instr[7:0]=0x3C and PCW=8: out_pc_jmp = 0x3C; all address fields 0; no scoreboard change.
REQ-038 Assert reset while a stall is pending on r1: afterwards out_valid=0, the scoreboard is clear, and add r2,r1,r1 issues immediately with operands 0.

Source files
------------

// File: rtl/decode_pipe_pkg.sv
// decode_pipe_pkg -- shared definitions for the decode pipeline slice.
//   opcode_e      : MIPS opcodes the decoder recognises
//   dec_class_e   : operand-usage class derived from the opcode
//   dec_ctl_t     : per-class source/destination usage flags
//   PCW_DEFAULT   : default jump-target width
//   op_class()    : opcode -> class
//   class_ctl()   : class  -> usage flags
package decode_pipe_pkg;

  localparam int PCW_DEFAULT = 8;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // RRR: rs,rt -> rd   RI: rs -> rt   RR: rs,rt, no dst   NONE: no operands
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_RRR  = 2'd1,
    CLS_RI   = 2'd2,
    CLS_RR   = 2'd3
  } dec_class_e;

  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic dst_rd;
    logic dst_rt;
  } dec_ctl_t;

  function automatic dec_class_e op_class(input logic [5:0] op);
    dec_class_e cls;
    case (op)
      OP_RTYPE:      cls = CLS_RRR;
      OP_ADDI, OP_LW: cls = CLS_RI;
      OP_BEQ, OP_SW: cls = CLS_RR;
      default:       cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  function automatic dec_ctl_t class_ctl(input dec_class_e cls);
    dec_ctl_t ctl;
    case (cls)
      CLS_RRR: ctl = '{use_rs: 1'b1, use_rt: 1'b1, dst_rd: 1'b1, dst_rt: 1'b0};
      CLS_RI:  ctl = '{use_rs: 1'b1, use_rt: 1'b0, dst_rd: 1'b0, dst_rt: 1'b1};
      CLS_RR:  ctl = '{use_rs: 1'b1, use_rt: 1'b1, dst_rd: 1'b0, dst_rt: 1'b0};
      default: ctl = '{use_rs: 1'b0, use_rt: 1'b0, dst_rd: 1'b0, dst_rt: 1'b0};
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// decode_pipe_if -- bundles the fetch handshake, the writeback channels,
// the decoded-bundle handshake to execute and the stall counter.
//   master : environment side (drives in_*, wb_*, out_ready)
//   slave  : decode_pipe side (drives in_ready, out_*, stall_cnt)
interface decode_pipe_if
  import decode_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WB_PORTS = 2,
  parameter int PCW      = PCW_DEFAULT
);
  localparam int RA = $clog2(NREGS);

  logic                               in_valid;
  logic                               in_ready;
  logic [31:0]                        in_instr;
  logic [WB_PORTS-1:0]                wb_en;
  logic [WB_PORTS-1:0][RA-1:0]        wb_addr;
  logic [WB_PORTS-1:0][XLEN-1:0]      wb_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [5:0]                         out_op;
  logic [RA-1:0]                      out_rs_a;
  logic [RA-1:0]                      out_rt_a;
  logic [RA-1:0]                      out_rd_a;
  logic [XLEN-1:0]                    out_rs;
  logic [XLEN-1:0]                    out_rt;
  logic [XLEN-1:0]                    out_imm;
  logic [PCW-1:0]                     out_pc_jmp;
  logic [15:0]                        stall_cnt;

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_op, out_rs_a, out_rt_a, out_rd_a,
           out_rs, out_rt, out_imm, out_pc_jmp, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_op, out_rs_a, out_rt_a, out_rd_a,
           out_rs, out_rt, out_imm, out_pc_jmp, stall_cnt
  );

endinterface

// File: rtl/decode_pipe_regfile_mp.sv
// regfile_mp -- multi-write-port register file with two asynchronous reads.
//   clk, reset        : clock, synchronous active-low reset (clears all entries)
//   we/waddr/wdata    : WB_PORTS write ports; highest port index wins a collision
//   raddr_a/rdata_a   : asynchronous read port A
//   raddr_b/rdata_b   : asynchronous read port B
// Register 0 is never written and always reads 0.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WB_PORTS = 2,
  parameter int RA       = $clog2(NREGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WB_PORTS-1:0]           we,
  input  logic [WB_PORTS-1:0][RA-1:0]   waddr,
  input  logic [WB_PORTS-1:0][XLEN-1:0] wdata,
  input  logic [RA-1:0]                 raddr_a,
  output logic [XLEN-1:0]               rdata_a,
  input  logic [RA-1:0]                 raddr_b,
  output logic [XLEN-1:0]               rdata_b
);

  logic [XLEN-1:0] regs_r [NREGS];

  // Storage update: ports applied in ascending order so the last (highest) wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (we[p] && (waddr[p] != '0)) begin
          regs_r[waddr[p]] <= wdata[p];
        end
      end
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_r[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_r[raddr_b];

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe -- single-stage MIPS decode with register read, scoreboard
// hazard detection and a one-deep registered output bundle.
//   clk, reset : clock, synchronous active-low reset
//   bus        : decode_pipe_if.slave (fetch handshake, writeback channels,
//                decoded bundle to execute, stall counter)
// Optional feature: define DECODE_BYPASS_EN to let a same-cycle writeback
// satisfy a pending source (operand taken from wb_data). Without it the
// instruction waits one cycle and reads the register file.
// Assumes NREGS <= 32 (register fields are 5 bits), XLEN >= 16, PCW <= 32.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int WB_PORTS = 2,
  parameter int PCW      = PCW_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  decode_pipe_if.slave bus
);

  localparam int RA = $clog2(NREGS);
`ifdef DECODE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [5:0]      op_s;
  dec_ctl_t        ctl_s;
  logic [RA-1:0]   rs_f_s, rt_f_s, rd_f_s;
  logic [RA-1:0]   rs_rd_s, rt_rd_s;
  logic [RA-1:0]   rt_a_s, rd_a_s, dst_a_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rf_rs_s, rf_rt_s;
  logic [XLEN-1:0] rs_byp_s, rt_byp_s;
  logic [XLEN-1:0] rs_val_s, rt_val_s;
  logic            rs_hit_s, rt_hit_s;
  logic            hazard_s, in_ready_s, issue_s;
  logic [NREGS-1:0] clr_vec_s, pend_next_s;

  logic [NREGS-1:0] pend_r;
  logic             out_valid_r;
  logic [5:0]       out_op_r;
  logic [RA-1:0]    out_rs_a_r, out_rt_a_r, out_rd_a_r;
  logic [XLEN-1:0]  out_rs_r, out_rt_r, out_imm_r;
  logic [PCW-1:0]   out_pc_jmp_r;
  logic [15:0]      stall_cnt_r;

  // Field extraction and decode. Read addresses are forced to 0 for unused
  // sources so they read 0 and can never hazard; the rt address output also
  // reports rt when it is the destination.
  always_comb begin
    op_s     = bus.in_instr[31:26];
    ctl_s    = class_ctl(op_class(op_s));
    rs_f_s   = bus.in_instr[21 +: RA];
    rt_f_s   = bus.in_instr[16 +: RA];
    rd_f_s   = bus.in_instr[11 +: RA];
    rs_rd_s  = ctl_s.use_rs ? rs_f_s : '0;
    rt_rd_s  = ctl_s.use_rt ? rt_f_s : '0;
    rt_a_s   = (ctl_s.use_rt || ctl_s.dst_rt) ? rt_f_s : '0;
    rd_a_s   = ctl_s.dst_rd ? rd_f_s : '0;
    dst_a_s  = ctl_s.dst_rd ? rd_f_s : (ctl_s.dst_rt ? rt_f_s : '0);
    imm_s    = {{(XLEN-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
  end

  // Writeback scan: scoreboard clear vector plus per-source match and the
  // winning (highest-channel) data for forwarding.
  always_comb begin
    clr_vec_s = '0;
    rs_hit_s  = 1'b0;
    rt_hit_s  = 1'b0;
    rs_byp_s  = '0;
    rt_byp_s  = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      clr_vec_s[bus.wb_addr[p]] = clr_vec_s[bus.wb_addr[p]] | bus.wb_en[p];
      rs_hit_s = rs_hit_s | (bus.wb_en[p] && (bus.wb_addr[p] == rs_rd_s));
      rt_hit_s = rt_hit_s | (bus.wb_en[p] && (bus.wb_addr[p] == rt_rd_s));
      rs_byp_s = (bus.wb_en[p] && (bus.wb_addr[p] == rs_rd_s)) ? bus.wb_data[p] : rs_byp_s;
      rt_byp_s = (bus.wb_en[p] && (bus.wb_addr[p] == rt_rd_s)) ? bus.wb_data[p] : rt_byp_s;
    end
  end

  // Hazard, operand selection, handshake and next scoreboard state.
  always_comb begin
    hazard_s = (pend_r[rs_rd_s] && !(BYPASS && rs_hit_s)) ||
               (pend_r[rt_rd_s] && !(BYPASS && rt_hit_s));
    rs_val_s = (BYPASS && rs_hit_s && (rs_rd_s != '0)) ? rs_byp_s : rf_rs_s;
    rt_val_s = (BYPASS && rt_hit_s && (rt_rd_s != '0)) ? rt_byp_s : rf_rt_s;
    in_ready_s = (!out_valid_r || bus.out_ready) && !hazard_s;
    issue_s    = bus.in_valid && in_ready_s;
    // Set is applied after clear so an issue beats a same-cycle writeback.
    pend_next_s = pend_r & ~clr_vec_s;
    pend_next_s[dst_a_s] = pend_next_s[dst_a_s] | (issue_s && (dst_a_s != '0));
    pend_next_s[0] = 1'b0;
  end

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .WB_PORTS (WB_PORTS),
    .RA       (RA)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_en),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (rs_rd_s),
    .rdata_a (rf_rs_s),
    .raddr_b (rt_rd_s),
    .rdata_b (rf_rt_s)
  );

  // Output bundle, scoreboard and stall counter. The bundle is only loaded on
  // issue, so it holds while execute back-pressures.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_r  <= 1'b0;
      out_op_r     <= 6'd0;
      out_rs_a_r   <= '0;
      out_rt_a_r   <= '0;
      out_rd_a_r   <= '0;
      out_rs_r     <= '0;
      out_rt_r     <= '0;
      out_imm_r    <= '0;
      out_pc_jmp_r <= '0;
      pend_r       <= '0;
      stall_cnt_r  <= 16'd0;
    end else begin
      if (issue_s) begin
        out_valid_r  <= 1'b1;
        out_op_r     <= op_s;
        out_rs_a_r   <= rs_rd_s;
        out_rt_a_r   <= rt_a_s;
        out_rd_a_r   <= rd_a_s;
        out_rs_r     <= rs_val_s;
        out_rt_r     <= rt_val_s;
        out_imm_r    <= imm_s;
        out_pc_jmp_r <= bus.in_instr[PCW-1:0];
      end else if (bus.out_ready) begin
        out_valid_r  <= 1'b0;
      end else begin
        out_valid_r  <= out_valid_r;
      end
      pend_r <= pend_next_s;
      if (bus.in_valid && hazard_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_op     = out_op_r;
  assign bus.out_rs_a   = out_rs_a_r;
  assign bus.out_rt_a   = out_rt_a_r;
  assign bus.out_rd_a   = out_rd_a_r;
  assign bus.out_rs     = out_rs_r;
  assign bus.out_rt     = out_rt_r;
  assign bus.out_imm    = out_imm_r;
  assign bus.out_pc_jmp = out_pc_jmp_r;
  assign bus.stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe -- directed scenarios plus randomized traffic for decode_pipe,
// checked against a behavioural model of the decode/scoreboard rules.
// Build with or without DECODE_BYPASS_EN; the model follows the same macro.
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  localparam int XLEN = 32, NREGS = 32, WB_PORTS = 2, PCW = 8;

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_pipe_if #(.XLEN(XLEN), .NREGS(NREGS), .WB_PORTS(WB_PORTS), .PCW(PCW)) bus ();

  decode_pipe #(.XLEN(XLEN), .NREGS(NREGS), .WB_PORTS(WB_PORTS), .PCW(PCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [NREGS];
  bit          m_pend [NREGS];
  bit          m_valid;
  logic [15:0] m_stall;
  logic [5:0]  m_op;
  logic [4:0]  m_rs_a, m_rt_a, m_rd_a;
  logic [31:0] m_rs, m_rt, m_imm;
  logic [7:0]  m_pc;

  // Decode table: address outputs, source registers (0 when unused), destination.
  function automatic void spec_decode(input logic [31:0] ins, output int rs_a, output int rt_a,
                                      output int rd_a, output int src_b, output int dst);
    int rs, rt, rd;
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    case (ins[31:26])
      6'h00:        begin rs_a = rs; rt_a = rt; rd_a = rd; src_b = rt; dst = rd; end
      6'h08, 6'h23: begin rs_a = rs; rt_a = rt; rd_a = 0;  src_b = 0;  dst = rt; end
      6'h04, 6'h2B: begin rs_a = rs; rt_a = rt; rd_a = 0;  src_b = rt; dst = 0;  end
      default:      begin rs_a = 0;  rt_a = 0;  rd_a = 0;  src_b = 0;  dst = 0;  end
    endcase
  endfunction

  // Is register a written this cycle? d gets the highest-channel data.
  function automatic bit wb_hits(input int a, output logic [31:0] d);
    bit h;
    h = 1'b0; d = 32'd0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_en[p] && (int'(bus.wb_addr[p]) == a)) begin h = 1'b1; d = bus.wb_data[p]; end
    end
    return h;
  endfunction

  function automatic bit src_blocked(input int s);
    logic [31:0] d;
    bit h;
    h = wb_hits(s, d);
    return m_pend[s] && !(BYP && h);
  endfunction

  function automatic bit model_hazard();
    int ra, ta, da, sb, dst;
    spec_decode(bus.in_instr, ra, ta, da, sb, dst);
    return src_blocked(ra) || src_blocked(sb);
  endfunction

  function automatic bit model_ready();
    return (!m_valid || bus.out_ready) && !model_hazard();
  endfunction

  function automatic logic [31:0] operand(input int s);
    logic [31:0] d;
    bit h;
    h = wb_hits(s, d);
    if (BYP && h && s != 0) return d;
    return m_regs[s];
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    int ra, ta, da, sb, dst;
    bit haz, issue;
    if (reset === 1'b0) begin
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = 32'd0; m_pend[i] = 1'b0; end
      m_valid = 1'b0; m_stall = 16'd0; m_op = 6'd0; m_rs_a = 5'd0; m_rt_a = 5'd0; m_rd_a = 5'd0;
      m_rs = 32'd0; m_rt = 32'd0; m_imm = 32'd0; m_pc = 8'd0;
      return;
    end
    spec_decode(bus.in_instr, ra, ta, da, sb, dst);
    haz   = model_hazard();
    issue = bus.in_valid && model_ready();
    if (bus.in_valid && haz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (issue) begin
      m_valid = 1'b1;
      m_op = bus.in_instr[31:26];
      m_rs_a = 5'(ra); m_rt_a = 5'(ta); m_rd_a = 5'(da);
      m_rs = operand(ra); m_rt = operand(sb);
      m_imm = 32'($signed(bus.in_instr[15:0]));
      m_pc = bus.in_instr[7:0];
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_en[p] && bus.wb_addr[p] != 5'd0) begin
        m_regs[bus.wb_addr[p]] = bus.wb_data[p];
      end
      if (bus.wb_en[p]) m_pend[bus.wb_addr[p]] = 1'b0;
    end
    if (issue && dst != 0) m_pend[dst] = 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.out_ready = 1'b1;
    bus.wb_en = '0; bus.wb_addr = '0; bus.wb_data = '0;
  endtask

  task automatic wb0(input logic [4:0] a, input logic [31:0] d);
    bus.wb_en = 2'b01; bus.wb_addr[0] = a; bus.wb_data[0] = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %h want 0", bus.stall_cnt); end
    vectors++; if (bus.out_op !== 6'd0 || bus.out_rs !== 32'd0 || bus.out_imm !== 32'd0) begin
      miscompares++; $display("FAIL reset_fields: op %h rs %h imm %h want 0", bus.out_op, bus.out_rs, bus.out_imm); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_stall();
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = mk_i(6'h08, 5'd0, 5'd1, 16'd5); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL addi_ready: got %b want 1", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_op !== 6'h08 || bus.out_rt_a !== 5'd1 || bus.out_rd_a !== 5'd0 || bus.out_imm !== 32'd5) begin
      miscompares++; $display("FAIL addi_bundle: v %b op %h rt_a %0d rd_a %0d imm %h want 1/08/1/0/5",
                              bus.out_valid, bus.out_op, bus.out_rt_a, bus.out_rd_a, bus.out_imm); end
    bus.in_instr = mk_r(5'd1, 5'd1, 5'd2); #1;
    for (int i = 1; i <= 3; i++) begin
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b want 0", bus.in_ready); end
      tick();
      vectors++; if (bus.stall_cnt !== 16'(i)) begin miscompares++; $display("FAIL stall_cnt: got %0d want %0d", bus.stall_cnt, i); end
    end
    wb0(5'd1, 32'd5); #1;
`ifdef DECODE_BYPASS_EN
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL byp_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.wb_en = '0;
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_rs !== 32'd5 || bus.out_rt !== 32'd5 || bus.out_rd_a !== 5'd2 || bus.stall_cnt !== 16'd3) begin
      miscompares++; $display("FAIL byp_issue: v %b rs %h rt %h rd_a %0d stall %0d want 1/5/5/2/3",
                              bus.out_valid, bus.out_rs, bus.out_rt, bus.out_rd_a, bus.stall_cnt); end
`else
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL nobyp_ready: got %b want 0", bus.in_ready); end
    tick();
    bus.wb_en = '0; #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL nobyp_ready2: got %b want 1", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_rs !== 32'd5 || bus.out_rt !== 32'd5 || bus.out_rd_a !== 5'd2 || bus.stall_cnt !== 16'd4) begin
      miscompares++; $display("FAIL nobyp_issue: v %b rs %h rt %h rd_a %0d stall %0d want 1/5/5/2/4",
                              bus.out_valid, bus.out_rs, bus.out_rt, bus.out_rd_a, bus.stall_cnt); end
`endif
    idle(); tick();
  endtask

  task automatic test_wb_priority();
    do_reset();
    bus.wb_en = 2'b11; bus.wb_addr[0] = 5'd3; bus.wb_addr[1] = 5'd3;
    bus.wb_data[0] = 32'hA; bus.wb_data[1] = 32'hB;
    tick();
    bus.wb_en = '0;
    bus.in_valid = 1'b1; bus.in_instr = mk_i(6'h2B, 5'd0, 5'd3, 16'h0010);
    tick();
    vectors++; if (bus.out_rt !== 32'hB || bus.out_rt_a !== 5'd3 || bus.out_rd_a !== 5'd0 || bus.out_rs !== 32'd0) begin
      miscompares++; $display("FAIL wb_priority: rt %h rt_a %0d rd_a %0d rs %h want B/3/0/0",
                              bus.out_rt, bus.out_rt_a, bus.out_rd_a, bus.out_rs); end
    idle(); tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    wb0(5'd6, 32'h55); tick(); bus.wb_en = '0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = mk_i(6'h08, 5'd6, 5'd4, 16'hFFF0); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_first_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_instr = mk_i(6'h08, 5'd0, 5'd5, 16'd1);
    wb0(5'd6, 32'h99);
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b want 0", bus.in_ready); end
      tick();
      bus.wb_en = '0;
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_rs !== 32'h55 || bus.out_imm !== 32'hFFFFFFF0 ||
                     bus.out_rt_a !== 5'd4 || bus.out_rs_a !== 5'd6) begin
        miscompares++; $display("FAIL bp_hold: v %b rs %h imm %h rt_a %0d rs_a %0d want 1/55/fffffff0/4/6",
                                bus.out_valid, bus.out_rs, bus.out_imm, bus.out_rt_a, bus.out_rs_a); end
    end
    bus.out_ready = 1'b1; #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_rt_a !== 5'd5 || bus.out_imm !== 32'd1) begin
      miscompares++; $display("FAIL bp_next: v %b rt_a %0d imm %h want 1/5/1", bus.out_valid, bus.out_rt_a, bus.out_imm); end
    idle(); tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_jump();
    logic [25:0] tgt;
    do_reset();
    tgt = 26'h3FFFF3C;
    bus.in_valid = 1'b1; bus.in_instr = {6'h02, tgt};
    tick();
    vectors++; if (bus.out_op !== 6'h02 || bus.out_pc_jmp !== 8'h3C || bus.out_rs_a !== 5'd0 ||
                   bus.out_rt_a !== 5'd0 || bus.out_rd_a !== 5'd0) begin
      miscompares++; $display("FAIL jump: op %h pc %h rs_a %0d rt_a %0d rd_a %0d want 02/3c/0/0/0",
                              bus.out_op, bus.out_pc_jmp, bus.out_rs_a, bus.out_rt_a, bus.out_rd_a); end
    bus.in_instr = mk_r(5'd31, 5'd31, 5'd1); #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL jump_no_pending: got %b want 1", bus.in_ready); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = mk_i(6'h08, 5'd0, 5'd1, 16'd7);
    tick();
    bus.in_instr = mk_r(5'd1, 5'd1, 5'd2); bus.out_ready = 1'b0;
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.stall_cnt !== 16'd1) begin
      miscompares++; $display("FAIL pre_reset: v %b stall %0d want 1/1", bus.out_valid, bus.stall_cnt); end
    reset = 1'b0;
    tick();
    vectors++; if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.out_imm !== 32'd0) begin
      miscompares++; $display("FAIL mid_reset: v %b stall %0d imm %h want 0/0/0", bus.out_valid, bus.stall_cnt, bus.out_imm); end
    reset = 1'b1; bus.out_ready = 1'b1; #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_rs !== 32'd0 || bus.out_rt !== 32'd0 ||
                   bus.out_rd_a !== 5'd2 || bus.out_rs_a !== 5'd1) begin
      miscompares++; $display("FAIL post_reset_issue: v %b rs %h rt %h rd_a %0d rs_a %0d want 1/0/0/2/1",
                              bus.out_valid, bus.out_rs, bus.out_rt, bus.out_rd_a, bus.out_rs_a); end
    idle(); tick();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [124:0] got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ins = $urandom();
      case ($urandom_range(0, 6))
        0: ins[31:26] = 6'h00;
        1: ins[31:26] = 6'h08;
        2: ins[31:26] = 6'h23;
        3: ins[31:26] = 6'h04;
        4: ins[31:26] = 6'h2B;
        5: ins[31:26] = 6'h02;
        default: ins[31:26] = 6'($urandom());
      endcase
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      bus.in_instr  = ins;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < WB_PORTS; p++) begin
        bus.wb_en[p]   = ($urandom_range(0, 9) < 3);
        bus.wb_addr[p] = 5'($urandom_range(0, 7));
        bus.wb_data[p] = $urandom();
      end
      #1;
      vectors++; if (bus.in_ready !== model_ready()) begin
        miscompares++; $display("FAIL rnd_ready cyc %0d: got %b want %b", c, bus.in_ready, model_ready()); end
      tick();
      vectors++; if (bus.out_valid !== m_valid) begin
        miscompares++; $display("FAIL rnd_valid cyc %0d: got %b want %b", c, bus.out_valid, m_valid); end
      vectors++; if (bus.stall_cnt !== m_stall) begin
        miscompares++; $display("FAIL rnd_stall cyc %0d: got %0d want %0d", c, bus.stall_cnt, m_stall); end
      if (m_valid) begin
        got = {bus.out_op, bus.out_rs_a, bus.out_rt_a, bus.out_rd_a, bus.out_rs, bus.out_rt, bus.out_imm, bus.out_pc_jmp};
        exp = {m_op, m_rs_a, m_rt_a, m_rd_a, m_rs, m_rt, m_imm, m_pc};
        vectors++; if (got !== exp) begin
          miscompares++; $display("FAIL rnd_bundle cyc %0d: got %h want %h", c, got, exp); end
      end
    end
    idle(); tick();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_stall();
    test_wb_priority();
    test_backpressure();
    test_jump();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
